// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the multiplexed scan controller.
package mux_scan_pkg;

  localparam int unsigned NUM_CH = 8;
  localparam int unsigned SEL_W  = 3;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SETTLE   = 2'd1,
    ST_SAMPLE   = 2'd2,
    ST_WAIT_OUT = 2'd3
  } scan_state_t;

endpackage

// File: rtl/mux_scan_next.sv
// Finds the lowest enabled channel strictly above idx; idx = -1 finds the first enabled channel.
module mux_scan_next
  import mux_scan_pkg::*;
(
  input  logic [NUM_CH-1:0]     mask,
  input  logic signed [SEL_W:0] idx,
  output logic [SEL_W-1:0]      next_idx,
  output logic                  found
);

  // Ascending priority search above idx
  always_comb begin
    next_idx = '0;
    found    = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (!found && mask[i] && (int'(i) > int'(idx))) begin
        next_idx = SEL_W'(i);
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scan controller: steps an external 8:1 mux through enabled channels and assembles a frame.
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int unsigned SETTLE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              cont,
  input  logic [NUM_CH-1:0] ch_en,
  output logic [SEL_W-1:0]  sel,
  input  logic              mux_out,
  output logic [NUM_CH-1:0] frame,
  output logic              frame_valid,
  input  logic              frame_ready,
  output logic              busy
);

  // SETTLE=0 skips the settle state entirely so each channel still gets SETTLE+1 cycles.
  localparam scan_state_t      ENTRY_ST    = (SETTLE == 0) ? ST_SAMPLE : ST_SETTLE;
  localparam logic [CNT_W-1:0] SETTLE_LOAD = (SETTLE == 0) ? '0 : CNT_W'(SETTLE - 1);

  scan_state_t       state;
  logic [NUM_CH-1:0] mask;
  logic [NUM_CH-1:0] shadow;
  logic [NUM_CH-1:0] shadow_upd;
  logic [CNT_W-1:0]  cnt;

  logic [SEL_W-1:0]  start_idx;
  logic              start_found;
  logic [SEL_W-1:0]  nxt_idx;
  logic              nxt_found;
  logic [SEL_W-1:0]  restart_idx;
  logic              restart_found;

  logic              accept;
  logic              out_free;

  mux_scan_next u_first_new (
    .mask     (ch_en),
    .idx      ('1),
    .next_idx (start_idx),
    .found    (start_found)
  );

  mux_scan_next u_next (
    .mask     (mask),
    .idx      ($signed({1'b0, sel})),
    .next_idx (nxt_idx),
    .found    (nxt_found)
  );

  mux_scan_next u_first_latched (
    .mask     (mask),
    .idx      ('1),
    .next_idx (restart_idx),
    .found    (restart_found)
  );

  assign accept   = frame_valid && frame_ready;
  assign out_free = !frame_valid || frame_ready;
  assign busy     = (state != ST_IDLE);

  // Shadow word with the bit currently on mux_out merged in
  always_comb begin
    shadow_upd      = shadow;
    shadow_upd[sel] = mux_out;
  end

  // Scan FSM, shadow assembly and output frame register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      sel         <= '0;
      mask        <= '0;
      shadow      <= '0;
      cnt         <= '0;
      frame       <= '0;
      frame_valid <= 1'b0;
    end else begin
      if (accept) frame_valid <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (start && start_found) begin
            mask   <= ch_en;
            sel    <= start_idx;
            shadow <= '0;
            cnt    <= SETTLE_LOAD;
            state  <= ENTRY_ST;
          end
        end

        ST_SETTLE: begin
          if (cnt == '0) state <= ST_SAMPLE;
          else           cnt   <= cnt - 1'b1;
        end

        ST_SAMPLE: begin
          if (nxt_found) begin
            shadow <= shadow_upd;
            sel    <= nxt_idx;
            cnt    <= SETTLE_LOAD;
            state  <= ENTRY_ST;
          end else if (out_free) begin
            frame       <= shadow_upd;
            frame_valid <= 1'b1;
            if (cont && restart_found) begin
              sel    <= restart_idx;
              shadow <= '0;
              cnt    <= SETTLE_LOAD;
              state  <= ENTRY_ST;
            end else begin
              sel    <= '0;
              shadow <= '0;
              state  <= ST_IDLE;
            end
          end else begin
            shadow <= shadow_upd;
            state  <= ST_WAIT_OUT;
          end
        end

        ST_WAIT_OUT: begin
          if (accept) begin
            frame       <= shadow;
            frame_valid <= 1'b1;
            if (cont && restart_found) begin
              sel    <= restart_idx;
              shadow <= '0;
              cnt    <= SETTLE_LOAD;
              state  <= ENTRY_ST;
            end else begin
              sel    <= '0;
              shadow <= '0;
              state  <= ST_IDLE;
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: cycle model for the SETTLE=1 instance plus directed literal checks.
module tb_mux_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] mux_in = 8'h00;

  // SETTLE=1 instance (modelled)
  logic       start = 1'b0, cont = 1'b0, frame_ready = 1'b0;
  logic [7:0] ch_en = 8'h00;
  logic [2:0] sel1;
  logic       mux_out1;
  logic [7:0] frame1;
  logic       fv1, busy1;

  // SETTLE=0 instance (literal checks only)
  logic       start0 = 1'b0;
  logic [7:0] ch_en0 = 8'h00;
  logic [2:0] sel0;
  logic       mux_out0;
  logic [7:0] frame0;
  logic       fv0, busy0;

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  assign mux_out1 = mux_in[sel1];
  assign mux_out0 = mux_in[sel0];

  mux_scan_ctrl #(.SETTLE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .cont(cont), .ch_en(ch_en),
    .sel(sel1), .mux_out(mux_out1), .frame(frame1), .frame_valid(fv1),
    .frame_ready(frame_ready), .busy(busy1)
  );

  mux_scan_ctrl #(.SETTLE(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .cont(1'b0), .ch_en(ch_en0),
    .sel(sel0), .mux_out(mux_out0), .frame(frame0), .frame_valid(fv0),
    .frame_ready(1'b1), .busy(busy0)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (scan schedule view) ----------------
  localparam int S = 1;
  bit         m_busy, m_stalled, m_fv;
  logic [7:0] m_mask, m_shadow, m_frame;
  int         m_k, m_t, m_n;
  int         m_list[8];

  task m_begin();
    m_busy = 1'b1; m_k = 0; m_t = 0; m_shadow = 8'h00; m_n = 0;
    for (int i = 0; i < 8; i++)
      if (m_mask[i]) begin m_list[m_n] = i; m_n++; end
  endtask

  task m_done();
    if (cont) m_begin();
    else m_busy = 1'b0;
  endtask

  always @(posedge clk or posedge rst) begin
    bit acc, ld;
    if (rst) begin
      m_busy = 0; m_stalled = 0; m_fv = 0; m_mask = 0; m_shadow = 0; m_frame = 0;
      m_k = 0; m_t = 0; m_n = 0;
    end else begin
      acc = m_fv && frame_ready;
      ld  = 1'b0;
      if (!m_busy) begin
        if (start && ch_en != 8'h00) begin m_mask = ch_en; m_begin(); end
      end else if (m_stalled) begin
        if (acc) begin m_frame = m_shadow; ld = 1'b1; m_stalled = 1'b0; m_done(); end
      end else begin
        m_t++;
        if (m_t == S + 1) begin
          m_shadow[m_list[m_k]] = mux_in[m_list[m_k]];
          m_t = 0;
          m_k++;
          if (m_k == m_n) begin
            if (!m_fv || acc) begin m_frame = m_shadow; ld = 1'b1; m_done(); end
            else m_stalled = 1'b1;
          end
        end
      end
      if (ld) m_fv = 1'b1;
      else if (acc) m_fv = 1'b0;
    end
  end

  // Per-cycle comparison of the SETTLE=1 instance against the model
  always @(posedge clk) begin
    int es;
    #1;
    if (!rst && chk_on) begin
      es = !m_busy ? 0 : (m_stalled ? m_list[m_n-1] : m_list[m_k]);
      chk("model_sel",   32'(sel1),  32'(es));
      chk("model_frame", 32'(frame1), 32'(m_frame));
      chk("model_fv",    32'(fv1),   32'(m_fv));
      chk("model_busy",  32'(busy1), 32'(m_busy));
    end
  end

  task automatic pulse_start(input logic [7:0] m);
    ch_en = m; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic accept_once();
    frame_ready = 1'b1;
    @(negedge clk);
    frame_ready = 1'b0;
  endtask

  initial begin
    #100000;
    bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sel", 32'(sel1), 0);
    chk("rst_frame", 32'(frame1), 0);
    chk("rst_fv", 32'(fv1), 0);
    chk("rst_busy", 32'(busy1), 0);
    @(negedge clk);
    rst = 1'b0;
    chk_on = 1'b1;

    // Full scan, SETTLE=1, mux inputs A5
    mux_in = 8'hA5;
    pulse_start(8'hFF);
    repeat (15) @(posedge clk);
    #1 chk("a5_fv_early", 32'(fv1), 0);
    @(posedge clk);
    #1;
    chk("a5_fv", 32'(fv1), 1);
    chk("a5_frame", 32'(frame1), 32'h A5);
    chk("a5_busy_low", 32'(busy1), 0);
    @(negedge clk);
    accept_once();
    chk("a5_consumed", 32'(fv1), 0);

    // SETTLE=0 instance, sparse mask 81
    mux_in = 8'hFF;
    ch_en0 = 8'h81; start0 = 1'b1;
    @(posedge clk);
    #1;
    chk("s0_sel_first", 32'(sel0), 0);
    chk("s0_busy", 32'(busy0), 1);
    @(negedge clk);
    start0 = 1'b0;
    @(posedge clk);
    #1 chk("s0_sel_second", 32'(sel0), 7);
    @(posedge clk);
    #1;
    chk("s0_frame", 32'(frame0), 32'h81);
    chk("s0_fv", 32'(fv0), 1);
    chk("s0_busy_low", 32'(busy0), 0);
    @(negedge clk);

    // Continuous mode with a stalled consumer
    cont = 1'b1; frame_ready = 1'b0; mux_in = 8'h3C;
    pulse_start(8'hFF);
    repeat (16) @(posedge clk);
    #1;
    chk("c_frame1", 32'(frame1), 32'h3C);
    chk("c_fv1", 32'(fv1), 1);
    @(negedge clk);
    mux_in = 8'hC3;
    repeat (20) @(posedge clk);
    #1;
    chk("c_stall_sel", 32'(sel1), 7);
    chk("c_stall_frame", 32'(frame1), 32'h3C);
    chk("c_stall_busy", 32'(busy1), 1);
    @(negedge clk);
    cont = 1'b0; frame_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("c_frame2", 32'(frame1), 32'hC3);
    chk("c_fv2", 32'(fv1), 1);
    chk("c_idle", 32'(busy1), 0);
    @(negedge clk);
    frame_ready = 1'b0;
    @(negedge clk);
    accept_once();
    chk("c_consumed", 32'(fv1), 0);

    // Reset mid-scan
    mux_in = 8'hFF;
    pulse_start(8'hFF);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("r_sel", 32'(sel1), 0);
    chk("r_frame", 32'(frame1), 0);
    chk("r_fv", 32'(fv1), 0);
    chk("r_busy", 32'(busy1), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("r_no_frame", 32'(fv1), 0);
    chk("r_stay_idle", 32'(busy1), 0);
    @(negedge clk);
    mux_in = 8'h5A;
    pulse_start(8'hFF);
    repeat (16) @(posedge clk);
    #1;
    chk("r_new_frame", 32'(frame1), 32'h5A);
    chk("r_new_fv", 32'(fv1), 1);
    @(negedge clk);
    accept_once();

    // Empty mask ignored; start during scan ignored
    pulse_start(8'h00);
    #1 chk("z_busy", 32'(busy1), 0);
    @(negedge clk);
    mux_in = 8'hFF;
    pulse_start(8'hF0);
    repeat (3) @(negedge clk);
    pulse_start(8'h0F);
    repeat (4) @(posedge clk);
    #1;
    chk("m_frame", 32'(frame1), 32'hF0);
    chk("m_fv", 32'(fv1), 1);
    @(negedge clk);
    accept_once();
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
